// File: rtl/alu_operand_regfile.sv
// W accumulator and general register file feeding the ALU, with writeback, immediate load and a 2-cycle W<->Rn exchange.
// Optional context shadow (W, carry, zero) is enabled with `define ALU_REGFILE_SHADOW_EN.
//
// state | meaning
// IDLE  | accepts writeback, immediate load, flag update, exchange start
// XCHG1 | W <= R[sel_q] (old W held in tmp)
// XCHG2 | R[sel_q] <= tmp, then back to IDLE
module alu_operand_regfile #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SEL_W-1:0]  Rn_sel,
    input  logic              wr_en,
    input  logic              wr_dest,
    input  logic              flags_en,
    input  logic              ld_imm_en,
    input  logic [DATA_W-1:0] imm_data,
    input  logic              xchg_start,
    input  logic [DATA_W-1:0] ALUResult_w,
    input  logic              carryF_w,
    input  logic              zeroF_w,
`ifdef ALU_REGFILE_SHADOW_EN
    input  logic              ctx_save,
    input  logic              ctx_restore,
`endif
    output logic [DATA_W-1:0] Wreg_w,
    output logic [DATA_W-1:0] Rn_w,
    output logic              carry_q,
    output logic              zero_q,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XCHG1 = 2'd1,
        XCHG2 = 2'd2
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_w;
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] r_tmp;
    logic [SEL_W-1:0]  r_sel;
    logic              r_carry;
    logic              r_zero;
    logic              r_busy;
`ifdef ALU_REGFILE_SHADOW_EN
    logic [DATA_W-1:0] r_sh_w;
    logic              r_sh_carry;
    logic              r_sh_zero;
`endif

    assign Wreg_w  = r_w;
    assign Rn_w    = r_regs[Rn_sel];
    assign carry_q = r_carry;
    assign zero_q  = r_zero;
    assign busy    = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_w     <= '0;
            r_tmp   <= '0;
            r_sel   <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
            r_busy  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
`ifdef ALU_REGFILE_SHADOW_EN
            r_sh_w     <= '0;
            r_sh_carry <= 1'b0;
            r_sh_zero  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (xchg_start) begin
                        r_sel   <= Rn_sel;
                        r_tmp   <= r_w;
                        r_busy  <= 1'b1;
                        r_state <= XCHG1;
                    end
`ifdef ALU_REGFILE_SHADOW_EN
                    else if (ctx_restore) begin
                        r_w     <= r_sh_w;
                        r_carry <= r_sh_carry;
                        r_zero  <= r_sh_zero;
                    end else if (ctx_save) begin
                        r_sh_w     <= r_w;
                        r_sh_carry <= r_carry;
                        r_sh_zero  <= r_zero;
                    end
`endif
                    else if (ld_imm_en) begin
                        // immediate load never touches the flags
                        if (wr_dest) r_regs[Rn_sel] <= imm_data;
                        else         r_w            <= imm_data;
                    end else begin
                        if (wr_en) begin
                            if (wr_dest) r_regs[Rn_sel] <= ALUResult_w;
                            else         r_w            <= ALUResult_w;
                        end
                        if (flags_en) begin
                            r_carry <= carryF_w;
                            r_zero  <= zeroF_w;
                        end
                    end
                end
                XCHG1: begin
                    r_w     <= r_regs[r_sel];
                    r_state <= XCHG2;
                end
                XCHG2: begin
                    r_regs[r_sel] <= r_tmp;
                    r_busy        <= 1'b0;
                    r_state       <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
